// File: rtl/set_pkg.sv
// set_pkg -- shared types and constants for the set-engine host.
//
// Contents:
//   mode_e       : job mode encoding seen by the set engine
//   host_state_e : set_host FSM states
//   JOB_W        : packed job width {central[23:0], radius[11:0], mode[1:0]}
//   FIFO_DEPTH   : number of queued jobs
//   TIMEOUT_MAX  : watchdog limit used when SET_HOST_TIMEOUT_EN is defined
package set_pkg;

  // Encoding 3 is reserved; the host forwards it without inspection.
  typedef enum logic [1:0] {
    MODE_A   = 2'd0,
    MODE_AND = 2'd1,
    MODE_XOR = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } host_state_e;

  localparam int JOB_W      = 38;
  localparam int FIFO_DEPTH = 4;

  localparam logic [9:0] TIMEOUT_MAX = 10'd1023;

endpackage

// File: rtl/set_job_fifo.sv
// set_job_fifo -- small synchronous FIFO holding pending host jobs.
//
// Ports:
//   clk, rst         : clock, asynchronous active-high reset (empties the FIFO)
//   push, wr_data    : write request and data; ignored while full
//   pop              : read request; ignored while empty
//   rd_data          : head entry (valid whenever empty = 0)
//   full, empty      : occupancy flags
//   count            : number of stored entries, 0..DEPTH
module set_job_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push while full is refused even if a pop happens in the same cycle;
  // the separate count register is what tells full from empty.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage has no reset; entries are only read once they have been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/set_host.sv
// set_host -- queues jobs for the set engine, issues them one at a time and
// returns each engine result through a valid/ready handshake.
//
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   job_valid/job_ready         : job input handshake
//   job_central/radius/mode     : job fields {x1,y1,x2,y2,8'h00}, {r1,r2,r3}, mode
//   en                          : one-cycle start pulse to the engine
//   central/radius/mode         : job fields held for the engine
//   busy                        : engine busy (monitored only, not used)
//   valid, candidate            : engine completion pulse and count
//   res_valid/res_ready         : result output handshake
//   res_candidate               : captured count
//   res_err                     : watchdog timeout flag (SET_HOST_TIMEOUT_EN only)
//
// Build option SET_HOST_TIMEOUT_EN: adds a 10-bit WAIT watchdog and res_err.
module set_host
  import set_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_central,
  input  logic [11:0] job_radius,
  input  logic [1:0]  job_mode,
  output logic        en,
  output logic [23:0] central,
  output logic [11:0] radius,
  output logic [1:0]  mode,
  input  logic        busy,
  input  logic        valid,
  input  logic [7:0]  candidate,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_candidate
`ifdef SET_HOST_TIMEOUT_EN
  ,
  output logic        res_err
`endif
);

  host_state_e state;
  host_state_e next_state;

  logic [JOB_W-1:0]                  fifo_rd_data;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;
  logic                              fifo_pop;

  logic capture_valid;
  logic capture_timeout;
  logic res_clear;

  // busy and the occupancy count are intentionally not used by the host.
  logic unused_inputs;
  assign unused_inputs = ^{busy, fifo_count};

  assign job_ready = ~fifo_full;

  set_job_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (job_valid),
    .wr_data ({job_central, job_radius, job_mode}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef SET_HOST_TIMEOUT_EN
  logic [9:0] watchdog;

  // Watchdog restarts on the way into WAIT (always from ISSUE) and counts
  // every WAIT cycle; leaving WAIT at the limit makes wrap irrelevant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      watchdog <= '0;
    end else if (state == ISSUE) begin
      watchdog <= '0;
    end else if (state == WAIT) begin
      watchdog <= watchdog + 10'd1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and control strobes. Only one job is ever outstanding:
  // en exists solely in ISSUE, and a new job is popped only from IDLE.
  always_comb begin
    next_state      = state;
    fifo_pop        = 1'b0;
    en              = 1'b0;
    capture_valid   = 1'b0;
    capture_timeout = 1'b0;
    res_clear       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !res_valid) begin
          fifo_pop   = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        en         = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (valid) begin
          capture_valid = 1'b1;
          next_state    = HOLD;
        end
`ifdef SET_HOST_TIMEOUT_EN
        else if (watchdog == TIMEOUT_MAX) begin
          capture_timeout = 1'b1;
          next_state      = HOLD;
        end
`endif
      end
      HOLD: begin
        if (res_valid && res_ready) begin
          res_clear  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Job fields for the engine change only when a job is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      central <= '0;
      radius  <= '0;
      mode    <= '0;
    end else if (fifo_pop) begin
      {central, radius, mode} <= fifo_rd_data;
    end
  end

  // Result register; a real completion takes priority over a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid     <= 1'b0;
      res_candidate <= '0;
`ifdef SET_HOST_TIMEOUT_EN
      res_err       <= 1'b0;
`endif
    end else if (capture_valid) begin
      res_valid     <= 1'b1;
      res_candidate <= candidate;
`ifdef SET_HOST_TIMEOUT_EN
      res_err       <= 1'b0;
`endif
    end else if (capture_timeout) begin
      res_valid     <= 1'b1;
      res_candidate <= '0;
`ifdef SET_HOST_TIMEOUT_EN
      res_err       <= 1'b1;
`endif
    end else if (res_clear) begin
      res_valid     <= 1'b0;
`ifdef SET_HOST_TIMEOUT_EN
      res_err       <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_set_host.sv
// tb_set_host -- directed self-checking bench for set_host.
// The bench plays the set engine: it waits for en, then pulses valid with a
// chosen candidate after a chosen latency.
module tb_set_host;

  logic        clk;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [23:0] job_central;
  logic [11:0] job_radius;
  logic [1:0]  job_mode;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy;
  logic        valid;
  logic [7:0]  candidate;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_candidate;
`ifdef SET_HOST_TIMEOUT_EN
  logic        res_err;
`endif

  int compared;
  int mismatched;
  int en_pulses;
  int job_en_base;

  logic [23:0] c_tab [6];
  logic [11:0] r_tab [6];
  logic [1:0]  m_tab [6];
  logic [7:0]  k_tab [6];

  set_host dut (
    .clk           (clk),
    .rst           (rst),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_central   (job_central),
    .job_radius    (job_radius),
    .job_mode      (job_mode),
    .en            (en),
    .central       (central),
    .radius        (radius),
    .mode          (mode),
    .busy          (busy),
    .valid         (valid),
    .candidate     (candidate),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_candidate (res_candidate)
`ifdef SET_HOST_TIMEOUT_EN
    ,
    .res_err       (res_err)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which en is high (value held through the cycle).
  initial en_pulses = 0;
  always @(posedge clk) begin
    if (!rst && en) en_pulses++;
  end

  // Hard stop in case something never terminates.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "[TB] aborted");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one job and wait (bounded) until it is accepted.
  task automatic applyStimulus(input logic [23:0] c, input logic [11:0] r,
                               input logic [1:0] m, output bit accepted);
    job_valid   = 1'b1;
    job_central = c;
    job_radius  = r;
    job_mode    = m;
    accepted    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (job_ready) begin
        accepted = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    job_valid = 1'b0;
  endtask

  task automatic waitEn(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (en) begin
        seen = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Issue-to-result for one job; returns with the result pending (HOLD).
  task automatic runJob(input int idx, input int lat);
    bit seen;
    bit stable;
    waitEn(seen);
    checkOutput($sformatf("en_seen_%0d", idx), 32'(seen), 32'd1);
    if (!seen) return;
    job_en_base = en_pulses;
    checkOutput($sformatf("central_%0d", idx), 32'(central), 32'(c_tab[idx]));
    checkOutput($sformatf("radius_%0d", idx), 32'(radius), 32'(r_tab[idx]));
    checkOutput($sformatf("mode_%0d", idx), 32'(mode), 32'(m_tab[idx]));
    busy = 1'b1;
    @(negedge clk);
    checkOutput($sformatf("en_width_%0d", idx), 32'(en), 32'd0);
    stable = 1'b1;
    repeat (lat - 1) begin
      if ({central, radius, mode} !== {c_tab[idx], r_tab[idx], m_tab[idx]}) stable = 1'b0;
      @(negedge clk);
    end
    valid     = 1'b1;
    candidate = k_tab[idx];
    @(negedge clk);
    valid     = 1'b0;
    candidate = 8'h00;
    busy      = 1'b0;
    checkOutput($sformatf("fields_stable_%0d", idx), 32'(stable), 32'd1);
    checkOutput($sformatf("res_valid_%0d", idx), 32'(res_valid), 32'd1);
    checkOutput($sformatf("res_candidate_%0d", idx), 32'(res_candidate), 32'(k_tab[idx]));
  endtask

  // Keep the result pending for 'hold' cycles, then complete the handshake.
  // Returns on the first cycle after the handshake.
  task automatic releaseResult(input string tag, input int hold);
    repeat (hold) @(negedge clk);
    checkOutput({tag, "_still_valid"}, 32'(res_valid), 32'd1);
    checkOutput({tag, "_one_en"}, 32'(en_pulses - job_en_base), 32'd1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput({tag, "_cleared"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    bit ok;
    int base;
    compared    = 0;
    mismatched  = 0;
    job_en_base = 0;
    rst         = 1'b1;
    job_valid   = 1'b0;
    job_central = '0;
    job_radius  = '0;
    job_mode    = '0;
    busy        = 1'b0;
    valid       = 1'b0;
    candidate   = '0;
    res_ready   = 1'b0;

    c_tab[0] = 24'h123400; r_tab[0] = 12'h345; m_tab[0] = 2'd0; k_tab[0] = 8'h50;
    c_tab[1] = 24'h456700; r_tab[1] = 12'h678; m_tab[1] = 2'd1; k_tab[1] = 8'h11;
    c_tab[2] = 24'h89AB00; r_tab[2] = 12'h9AB; m_tab[2] = 2'd2; k_tab[2] = 8'h22;
    c_tab[3] = 24'hCDEF00; r_tab[3] = 12'hCDE; m_tab[3] = 2'd3; k_tab[3] = 8'h33;
    c_tab[4] = 24'h102000; r_tab[4] = 12'hF01; m_tab[4] = 2'd1; k_tab[4] = 8'h44;
    c_tab[5] = 24'hFEDC00; r_tab[5] = 12'h123; m_tab[5] = 2'd2; k_tab[5] = 8'hFF;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_job_ready", 32'(job_ready), 32'd1);
    checkOutput("rst_en", 32'(en), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_fields", 32'({central, radius, mode} != '0), 32'd0);
    checkOutput("rst_res_candidate", 32'(res_candidate), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single nominal job, engine answers 576 cycles after en.
    $display("[TB] single job");
    applyStimulus(24'h444400, 12'h220, 2'd0, ok);
    checkOutput("single_accept", 32'(ok), 32'd1);
    c_tab[0] = 24'h444400; r_tab[0] = 12'h220; m_tab[0] = 2'd0; k_tab[0] = 8'd13;
    runJob(0, 576);
    releaseResult("single", 2);

    // Stray valid in IDLE is ignored.
    $display("[TB] stray valid");
    base      = en_pulses;
    valid     = 1'b1;
    candidate = 8'hAA;
    @(negedge clk);
    valid     = 1'b0;
    candidate = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("stray_res_valid", 32'(res_valid), 32'd0);
    checkOutput("stray_res_candidate", 32'(res_candidate), 32'd13);
    checkOutput("stray_no_en", 32'(en_pulses - base), 32'd0);

    // Long result stall with a second job queued.
    $display("[TB] result stall");
    c_tab[0] = 24'h123400; r_tab[0] = 12'h345; m_tab[0] = 2'd0; k_tab[0] = 8'h50;
    applyStimulus(c_tab[1], r_tab[1], m_tab[1], ok);
    applyStimulus(c_tab[2], r_tab[2], m_tab[2], ok);
    runJob(1, 10);
    releaseResult("stall", 100);
    checkOutput("stall_en_gap", 32'(en), 32'd0);
    @(negedge clk);
    checkOutput("stall_en_after_2", 32'(en), 32'd1);
    runJob(2, 10);
    releaseResult("stall2", 0);

    // Fill the FIFO while a result is pending downstream.
    $display("[TB] fifo full");
    applyStimulus(c_tab[0], r_tab[0], m_tab[0], ok);
    runJob(0, 8);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(c_tab[i], r_tab[i], m_tab[i], ok);
      checkOutput($sformatf("fill_accept_%0d", i), 32'(ok), 32'd1);
    end
    checkOutput("full_after_4", 32'(job_ready), 32'd0);
    job_valid   = 1'b1;
    job_central = c_tab[5];
    job_radius  = r_tab[5];
    job_mode    = m_tab[5];
    ok = 1'b0;
    repeat (5) begin
      if (job_ready) ok = 1'b1;
      @(negedge clk);
    end
    job_valid = 1'b0;
    checkOutput("fifth_held", 32'(ok), 32'd0);
    releaseResult("full0", 0);
    runJob(1, 8);
    releaseResult("full1", 0);
    applyStimulus(c_tab[5], r_tab[5], m_tab[5], ok);
    checkOutput("fifth_accept", 32'(ok), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      runJob(i, 8);
      releaseResult($sformatf("full%0d", i), 0);
    end

    // Reset in the middle of a job.
    $display("[TB] reset mid-job");
    applyStimulus(24'h111100, 12'h111, 2'd1, ok);
    waitEn(ok);
    checkOutput("rstjob_en", 32'(ok), 32'd1);
    repeat (300) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_en", 32'(en), 32'd0);
    checkOutput("midrst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("midrst_res_candidate", 32'(res_candidate), 32'd0);
    checkOutput("midrst_fields", 32'({central, radius, mode} != '0), 32'd0);
    checkOutput("midrst_job_ready", 32'(job_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("postrst_idle", 32'({en, res_valid}), 32'd0);
    applyStimulus(c_tab[3], r_tab[3], m_tab[3], ok);
    runJob(3, 20);
    releaseResult("fresh", 0);

`ifdef SET_HOST_TIMEOUT_EN
    // Engine never answers: watchdog produces an error result.
    $display("[TB] timeout");
    applyStimulus(c_tab[4], r_tab[4], m_tab[4], ok);
    waitEn(ok);
    checkOutput("to_en", 32'(ok), 32'd1);
    job_en_base = en_pulses;
    repeat (1024) @(negedge clk);
    checkOutput("to_not_yet", 32'(res_valid), 32'd0);
    @(negedge clk);
    checkOutput("to_res_valid", 32'(res_valid), 32'd1);
    checkOutput("to_res_err", 32'(res_err), 32'd1);
    checkOutput("to_res_candidate", 32'(res_candidate), 32'd0);
    releaseResult("to", 0);
    checkOutput("to_err_cleared", 32'(res_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/set_host.md
SET_HOST -- requirements
Module: set_host

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 job_valid  input  1  upstream job offer.
REQ-004 job_ready  output  1  job FIFO not full; a job is accepted when job_valid & job_ready.
REQ-005 job_central  input  24  {x1,y1,x2,y2,8'h00}, 4 bits each, MSB first.
REQ-006 job_radius  input  12  {r1,r2,r3}, 4 bits each; r3 is carried but not used by the responder.
REQ-007 job_mode  input  2  0 = A, 1 = A and B, 2 = A xor B; 3 is reserved.
REQ-008 en  output  1  one-cycle start pulse to the set engine.
REQ-009 central/radius/mode  output  24/12/2  job fields to the engine, held stable from en until valid is seen.
REQ-010 busy  input  1  engine busy; monitored only.
REQ-011 valid  input  1  one-cycle engine completion pulse.
REQ-012 candidate  input  8  engine count, sampled when valid = 1.
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  downstream accepts; transfer occurs when res_valid & res_ready.
REQ-015 res_candidate  output  8  captured count.
REQ-016 res_err  output  1  timeout flag; present only with SET_HOST_TIMEOUT_EN.

Function
REQ-017 Job FIFO: depth 4, width 38 ({central,radius,mode}); job_ready = ~full.
REQ-018 FIFO push and pop in the same cycle when full: the push is refused (job_ready = 0) and the pop proceeds.
REQ-019 FIFO pointers are 2 bits wide, wrap modulo 4, and an extra count register (0..4) distinguishes full from empty.
REQ-020 FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-021 IDLE -> ISSUE when the FIFO is not empty and res_valid = 0.
REQ-022 In that transition the head entry is popped and loaded into central/radius/mode.
REQ-023 ISSUE: en = 1 for exactly one cycle, then -> WAIT.
REQ-024 WAIT: when valid = 1, candidate is captured into res_candidate, res_valid is set, and the FSM -> HOLD.
REQ-025 In WAIT, busy is ignored; completion is signalled only by valid.
REQ-026 HOLD: when res_valid & res_ready, res_valid is cleared and the FSM -> IDLE.
REQ-027 Next-job latency: en rises no earlier than 2 cycles after the result handshake (IDLE, then ISSUE).
REQ-028 en is never asserted in WAIT or HOLD, so at most one job is outstanding.
REQ-029 central/radius/mode change only on the IDLE -> ISSUE transition.
REQ-030 valid arriving outside WAIT is ignored.
REQ-031 A mode = 3 job is forwarded unchanged; no check is made.
REQ-032 Nominal round trip is about 577 cycles (64 points x 9 cycles + 1); the host places no upper bound on it unless timeout is compiled in.

Reset
REQ-033 On rst: FSM = IDLE and the FIFO is emptied (job_ready = 1).
REQ-034 On rst: en, res_valid, res_err = 0; res_candidate, central, radius, mode = 0.
REQ-035 rst in mid-job aborts the job with no result produced; the engine is reset by the same rst.

Configuration
REQ-036 Macro SET_HOST_TIMEOUT_EN defined: a 10-bit watchdog clears on entry to WAIT and increments each cycle in WAIT.
REQ-037 With the macro, when the watchdog reaches 1023 and valid = 0: res_candidate = 0, res_err = 1, res_valid = 1, FSM -> HOLD.
REQ-038 With the macro, valid and watchdog = 1023 in the same cycle: valid wins and res_err = 0.
REQ-039 With the macro, res_err clears together with res_valid.
REQ-040 Macro undefined: no watchdog, no res_err port, and WAIT persists indefinitely.

Structure
REQ-041 Package set_pkg holds: mode enum (MODE_A = 0, MODE_AND = 1, MODE_XOR = 2); host state enum; JOB_W = 38; FIFO_DEPTH = 4; TIMEOUT_MAX = 1023.
REQ-042 The FIFO is the sub-module set_job_fifo (parameters for width and depth, push/pop/full/empty/count outputs); the FSM stays in set_host.

Verification
REQ-043 Single job central=24'h4444_00, radius=12'h220, mode=0; responder pulses valid with candidate=13 at 576 cycles after en -> exactly one en pulse, res_valid with res_candidate=13, outputs stable until valid.
REQ-044 Push 5 jobs back-to-back with the responder stalled -> job_ready=0 after the 4th push; the 5th is held; 4 results come out in order.
REQ-045 Hold res_ready=0 for 100 cycles after a result -> no en during the stall; en rises 2 cycles after the handshake.
REQ-046 Stray valid pulse in IDLE -> no res_valid and no state change.
REQ-047 Assert rst in WAIT at cycle 300 -> all outputs 0, FIFO empty; a fresh job then completes normally.
REQ-048 With SET_HOST_TIMEOUT_EN and a responder that never pulses valid -> res_valid=1, res_err=1, res_candidate=0 exactly 1023 cycles into WAIT.
